wu_inst_buffer: RTL and testbench
=================================

Name: wu_inst_buffer

Overview:
- Sits directly downstream of the WU fetch stage, on the WU memory read-data path.
- Captures WU words returned by WU memory and buffers them in a show-ahead FIFO.
- Presents the words to the WU decoder with a valid/ready handshake.
- Generates the early stall that throttles the fetch stage, so the words already in flight through the registered fetch/memory pipeline always fit.

Parameters:
- DATA_W, 64, width of one WU word.
- DEPTH, 8, FIFO entries; power of two, at least 4.
- SKID, 4, entries reserved for in-flight reads; stall asserts at count >= DEPTH-SKID. Must be less than DEPTH.
- FLUSH_BLANK, 3, cycles after flush during which returned memory data is discarded.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_poweron_n  in  1  synchronous, active-low reset.
- wum__wub__valid  in  1  WU memory read data valid this cycle.
- wum__wub__data  in  DATA_W  WU memory read data.
- mcntl__wub__flush  in  1  discard buffered and in-flight words (PC reload).
- wub__dec__valid  out  1  head word available.
- wub__dec__data  out  DATA_W  head word.
- dec__wub__ready  in  1  decoder accepts head word.
- wub__wuf__stall  out  1  registered stall to fetch stage.
- wub__mcntl__count  out  clog2(DEPTH)+1  current occupancy.
- wub__mcntl__overflow  out  1  sticky error flag.

Behaviour:
Reset:
- Applies at the clock edge while reset_poweron_n=0.
- Pointers=0, count=0, blank counter=0, stall=0, overflow=0, wub__dec__valid=0.
- wub__dec__data is don't-care while valid=0.
- Reset mid-operation discards all contents.

Storage:
- DEPTH x DATA_W register array; wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
- count is a separate register, 0..DEPTH.

Output:
- Show-ahead FIFO: wub__dec__valid = (count!=0); wub__dec__data = mem[rd_ptr].
- Both are driven from registers only; there is no combinational path from any input to these outputs.

Pop and push:
- pop = wub__dec__valid & dec__wub__ready.
- push = wum__wub__valid & ~blank & ~flush & (count<DEPTH | pop).
- Simultaneous push and pop when full is allowed; count is unchanged.
- Simultaneous push and pop when empty is not a bypass: the word becomes visible the next cycle.

Overflow:
- Condition: wum__wub__valid & ~blank & ~flush & count==DEPTH & ~pop.
- The word is dropped and wub__mcntl__overflow sets.
- The flag stays set until reset; flush does not clear it.

Stall:
- Registered: wub__wuf__stall <= (count_next >= DEPTH-SKID).
- Latency from the crossing edge is 1 cycle.
- Deasserts the cycle after count_next falls below the threshold.

Flush:
- mcntl__wub__flush=1 in cycle N has these effects at the edge ending N:
  - count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop in cycle N is suppressed (the decoder handshake in cycle N is ignored).
  - Blank counter loaded with FLUSH_BLANK.
- blank = (blank counter != 0).
- The blank counter decrements each cycle while nonzero.
- A flush while already blanking reloads the counter.
- Stall deasserts the cycle after flush.

Counts:
- wub__mcntl__count equals the count register.
- Widths: count uses clog2(DEPTH)+1 bits, with no wrap.

Test Plan:
1. Reset, then 5 consecutive valid words 0x11..0x15 with ready=1 -> decoder receives 0x11..0x15 in order, one per cycle; first valid 1 cycle after the first push; count never exceeds 1.
2. ready=0, DEPTH=8, SKID=4, valid words each cycle -> count 1,2,3,4; stall=1 the cycle after count reaches 4; words 5-8 are still accepted; count=8; overflow=0.
3. Full (count=8), ready=0, one more valid word 0xAA -> 0xAA dropped, overflow=1, count stays 8, head unchanged. Then ready=1 for 8 cycles -> original 8 words drain in order; overflow still 1.
4. Full with ready=1 and valid=1 in the same cycle -> one pop and one push, count stays 8, order preserved.
5. count=5 plus flush in cycle N, valid words in N+1..N+4 -> words in N+1..N+3 discarded, word at N+4 accepted; valid=0 in N+1..N+4; stall=0 from N+1.
6. Reset asserted (reset_poweron_n=0) for 1 cycle while count=6 and stall=1 -> count=0, valid=0, stall=0, overflow=0 on the next cycle; subsequent push behaves as in scenario 1.

Source files
------------

// File: rtl/wu_inst_buffer_if.sv
// wu_inst_buffer_if: memory read-data, decoder handshake and fetch/control signals of the WU instruction buffer
interface wu_inst_buffer_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
);
  logic              wum__wub__valid;
  logic [DATA_W-1:0] wum__wub__data;
  logic              mcntl__wub__flush;
  logic              wub__dec__valid;
  logic [DATA_W-1:0] wub__dec__data;
  logic              dec__wub__ready;
  logic              wub__wuf__stall;
  logic [$clog2(DEPTH):0] wub__mcntl__count;
  logic              wub__mcntl__overflow;
  modport master (
    output wum__wub__valid, wum__wub__data, mcntl__wub__flush, dec__wub__ready,
    input  wub__dec__valid, wub__dec__data, wub__wuf__stall, wub__mcntl__count, wub__mcntl__overflow
  );
  modport slave (
    input  wum__wub__valid, wum__wub__data, mcntl__wub__flush, dec__wub__ready,
    output wub__dec__valid, wub__dec__data, wub__wuf__stall, wub__mcntl__count, wub__mcntl__overflow
  );
endinterface

// File: rtl/wu_inst_buffer.sv
// wu_inst_buffer: show-ahead FIFO between WU memory and decoder with early fetch stall and post-flush blanking
module wu_inst_buffer #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 8,
  parameter int SKID        = 4,
  parameter int FLUSH_BLANK = 3
) (
  input logic clk,
  input logic reset_poweron_n,
  wu_inst_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = FLUSH_BLANK > 0 ? $clog2(FLUSH_BLANK + 1) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [BW-1:0] blank_cnt;
  logic flush, blank, take, pop_raw, pop, full, push, drop, stall, overflow;
  // pop_raw (handshake ignoring flush) decides whether a full FIFO can still take a word
  always_comb begin
    flush = bus.mcntl__wub__flush;
    blank = blank_cnt != '0;
    take = bus.wum__wub__valid & ~blank & ~flush;
    pop_raw = (count != '0) & bus.dec__wub__ready;
    pop = pop_raw & ~flush;
    full = count == CW'(DEPTH);
    push = take & (~full | pop_raw);
    drop = take & full & ~pop_raw;
    count_next = flush ? '0 : count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      blank_cnt <= '0;
      stall <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      count <= count_next;
      blank_cnt <= flush ? BW'(FLUSH_BLANK) : blank ? blank_cnt - BW'(1) : blank_cnt;
      stall <= count_next >= CW'(DEPTH - SKID);
      overflow <= overflow | drop;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.wum__wub__data;
  assign bus.wub__dec__valid = count != '0;
  assign bus.wub__dec__data = mem[rd_ptr];
  assign bus.wub__wuf__stall = stall;
  assign bus.wub__mcntl__count = count;
  assign bus.wub__mcntl__overflow = overflow;
endmodule

// File: tb/tb_wu_inst_buffer.sv
// tb_wu_inst_buffer: directed scenarios checked every cycle against a queue-based model plus literal checkpoints
module tb_wu_inst_buffer;
  localparam int DATA_W = 64, DEPTH = 8, SKID = 4, FLUSH_BLANK = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0;
  bit armed = 1'b0;
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] log_q[$];
  int blank_m = 0;
  bit stall_m = 1'b0, ovf_m = 1'b0;
  wu_inst_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  wu_inst_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKID(SKID), .FLUSH_BLANK(FLUSH_BLANK)) dut (
    .clk(clk), .reset_poweron_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a word queue, a blank countdown and the two flags, updated from the inputs seen at each edge
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      blank_m = 0;
      stall_m = 1'b0;
      ovf_m = 1'b0;
      armed = 1'b1;
    end else begin
      bit fl, acc, pp;
      fl = bus.mcntl__wub__flush;
      acc = bus.wum__wub__valid && blank_m == 0 && !fl;
      pp = q.size() > 0 && bus.dec__wub__ready;
      if (fl) begin
        q.delete();
        blank_m = FLUSH_BLANK;
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          if (q.size() < DEPTH) q.push_back(bus.wum__wub__data);
          else ovf_m = 1'b1;
        end
        if (blank_m > 0) blank_m--;
      end
      stall_m = q.size() >= DEPTH - SKID;
    end
  end
  always @(negedge clk) if (armed) begin
    check("valid", bus.wub__dec__valid, q.size() > 0);
    if (q.size() > 0) check("data", bus.wub__dec__data, q[0]);
    check("count", bus.wub__mcntl__count, q.size());
    check("stall", bus.wub__wuf__stall, stall_m);
    check("overflow", bus.wub__mcntl__overflow, ovf_m);
    if (rst_n && bus.wub__dec__valid && bus.dec__wub__ready && !bus.mcntl__wub__flush)
      log_q.push_back(bus.wub__dec__data);
  end
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    bus.wum__wub__valid = v;
    bus.wum__wub__data = d;
    bus.dec__wub__ready = r;
    bus.mcntl__wub__flush = f;
    @(posedge clk);
    #1;
  endtask
  task automatic check_log(input string name, input logic [DATA_W-1:0] first, input int n);
    check({name, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) check(name, log_q[i], first + i);
    log_q.delete();
  endtask
  initial begin
    bus.wum__wub__valid = 1'b0;
    bus.wum__wub__data = '0;
    bus.dec__wub__ready = 1'b0;
    bus.mcntl__wub__flush = 1'b0;
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    check("rst_count", bus.wub__mcntl__count, 0);
    check("rst_valid", bus.wub__dec__valid, 0);
    // scenario 1: streaming with ready high, never more than one word held
    cyc(1, 64'h11, 1, 0);
    check("s1_first_valid", bus.wub__dec__valid, 1);
    check("s1_first_data", bus.wub__dec__data, 64'h11);
    for (int i = 1; i < 5; i++) begin
      cyc(1, 64'h11 + i, 1, 0);
      check("s1_count", bus.wub__mcntl__count, 1);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check_log("s1_order", 64'h11, 5);
    // scenario 2: fill with ready low, stall at four
    for (int i = 0; i < 8; i++) begin
      cyc(1, 64'h21 + i, 0, 0);
      if (i == 2) check("s2_stall3", bus.wub__wuf__stall, 0);
      if (i == 3) check("s2_stall4", bus.wub__wuf__stall, 1);
    end
    check("s2_count", bus.wub__mcntl__count, 8);
    check("s2_ovf", bus.wub__mcntl__overflow, 0);
    // scenario 3: overflow drop then drain
    cyc(1, 64'hAA, 0, 0);
    check("s3_ovf", bus.wub__mcntl__overflow, 1);
    check("s3_count", bus.wub__mcntl__count, 8);
    check("s3_head", bus.wub__dec__data, 64'h21);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    check_log("s3_drain", 64'h21, 8);
    check("s3_ovf_sticky", bus.wub__mcntl__overflow, 1);
    // scenario 4: push and pop together while full
    for (int i = 0; i < 8; i++) cyc(1, 64'h31 + i, 0, 0);
    cyc(1, 64'h39, 1, 0);
    check("s4_count", bus.wub__mcntl__count, 8);
    check("s4_head", bus.wub__dec__data, 64'h32);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    check_log("s4_order", 64'h31, 9);
    // scenario 5: flush with five held, three blank cycles
    for (int i = 0; i < 5; i++) cyc(1, 64'h41 + i, 0, 0);
    check("s5_stall_pre", bus.wub__wuf__stall, 1);
    cyc(1, 64'h46, 1, 1);
    check("s5_count", bus.wub__mcntl__count, 0);
    check("s5_stall", bus.wub__wuf__stall, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 64'h47 + i, 0, 0);
      check("s5_blank_valid", bus.wub__dec__valid, 0);
    end
    cyc(1, 64'h4A, 0, 0);
    check("s5_accept_count", bus.wub__mcntl__count, 1);
    check("s5_accept_head", bus.wub__dec__data, 64'h4A);
    check("s5_ovf_kept", bus.wub__mcntl__overflow, 1);
    log_q.delete();
    // scenario 6: reset mid-operation at count six
    for (int i = 0; i < 5; i++) cyc(1, 64'h51 + i, 0, 0);
    check("s6_count_pre", bus.wub__mcntl__count, 6);
    rst_n = 1'b0;
    cyc(1, 64'h5F, 1, 0);
    rst_n = 1'b1;
    check("s6_count", bus.wub__mcntl__count, 0);
    check("s6_valid", bus.wub__dec__valid, 0);
    check("s6_stall", bus.wub__wuf__stall, 0);
    check("s6_ovf", bus.wub__mcntl__overflow, 0);
    log_q.delete();
    cyc(1, 64'h61, 1, 0);
    check("s6_push_valid", bus.wub__dec__valid, 1);
    check("s6_push_data", bus.wub__dec__data, 64'h61);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check_log("s6_order", 64'h61, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
